// File: rtl/enc_stage_1_decoder.sv
// Two-stage (8,4)/(16,11)/(32,26) single-error-correcting decoder.
// Define ECC_DEC_CNT_EN to add saturating corrected/uncorrectable word counters.
module enc_stage_1_decoder #(
   parameter int MAX_CODEWORD_WIDTH = 32,
   parameter int MAX_INFO_WIDTH     = 26,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
   input  logic [1:0]                    work_mod,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MAX_INFO_WIDTH-1:0]     data_out,
   output logic                          err_corr,
   output logic                          err_uncorr,
   output logic [4:0]                    err_pos,
   output logic [CNT_WIDTH-1:0]          corr_cnt,
   output logic [CNT_WIDTH-1:0]          uncorr_cnt,
   input  logic                          cnt_clr
);

   localparam int IW = MAX_INFO_WIDTH;
   localparam int PW = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;

   // Info column j is the j-th integer >= 3 that is not a power of two.
   localparam logic [PW-1:0] HCOL [IW] = '{
      6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11,
      6'd12, 6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19,
      6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26,
      6'd27, 6'd28, 6'd29, 6'd30, 6'd31
   };

   logic          s1_valid_q;
   logic [IW-1:0] s1_info_q, s1_info_d;
   logic [PW-1:0] s1_syn_q, s1_syn_d;
   logic [PW-1:0] s1_par_d;
   logic [1:0]    s1_mode_q;

   logic          out_valid_q;
   logic [IW-1:0] data_q, data_d;
   logic          corr_q, corr_d;
   logic          uncorr_q, uncorr_d;
   logic [4:0]    pos_q, pos_d;

   logic          s1_adv;

   assign s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s1_adv;

   always_comb begin
      s1_info_d = '0;
      s1_par_d  = '0;
      case (work_mod)
         2'b00: begin
            s1_info_d[3:0] = data_in[7:4];
            s1_par_d[3:0]  = data_in[3:0];
         end
         2'b01: begin
            s1_info_d[10:0] = data_in[15:5];
            s1_par_d[4:0]   = data_in[4:0];
         end
         2'b10: begin
            s1_info_d = data_in[31:6];
            s1_par_d  = data_in[5:0];
         end
         default: ;
      endcase
      s1_syn_d = s1_par_d;
      for (int j = 0; j < IW; j++) begin
         if (s1_info_d[j]) s1_syn_d = s1_syn_d ^ HCOL[j];
      end
   end

   always_comb begin
      int kk;
      int pp;
      data_d   = s1_info_q;
      corr_d   = 1'b0;
      uncorr_d = 1'b0;
      pos_d    = '0;
      case (s1_mode_q)
         2'b00:   begin kk = 4;  pp = 4; end
         2'b01:   begin kk = 11; pp = 5; end
         default: begin kk = 26; pp = 6; end
      endcase
      if (s1_mode_q == 2'b11) begin
         data_d   = '0;
         uncorr_d = 1'b1;
      end else if (s1_syn_q != '0) begin
         // Columns beyond K may alias a short-mode syndrome; ignore them.
         for (int j = 0; j < IW; j++) begin
            if (j < kk && HCOL[j] == s1_syn_q) begin
               data_d[j] = ~s1_info_q[j];
               corr_d    = 1'b1;
               pos_d     = 5'(pp + j);
            end
         end
         for (int k = 0; k < PW; k++) begin
            if (s1_syn_q == PW'(1 << k)) begin
               corr_d = 1'b1;
               pos_d  = 5'(k);
            end
         end
         uncorr_d = ~corr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_q  <= 1'b0;
         s1_info_q   <= '0;
         s1_syn_q    <= '0;
         s1_mode_q   <= '0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         corr_q      <= 1'b0;
         uncorr_q    <= 1'b0;
         pos_q       <= '0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_info_q <= s1_info_d;
               s1_syn_q  <= s1_syn_d;
               s1_mode_q <= work_mod;
            end
         end
         if (s1_adv) begin
            out_valid_q <= 1'b1;
            data_q      <= data_d;
            corr_q      <= corr_d;
            uncorr_q    <= uncorr_d;
            pos_q       <= pos_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign data_out   = data_q;
   assign err_corr   = corr_q;
   assign err_uncorr = uncorr_q;
   assign err_pos    = pos_q;

`ifdef ECC_DEC_CNT_EN
   logic                 hs;
   logic [CNT_WIDTH-1:0] corr_cnt_q;
   logic [CNT_WIDTH-1:0] uncorr_cnt_q;

   assign hs = out_valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else if (cnt_clr) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else if (hs) begin
         if (corr_q && !(&corr_cnt_q))
            corr_cnt_q <= corr_cnt_q + 1'b1;
         if (uncorr_q && !(&uncorr_cnt_q))
            uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
      end
   end

   assign corr_cnt   = corr_cnt_q;
   assign uncorr_cnt = uncorr_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign corr_cnt       = '0;
   assign uncorr_cnt     = '0;
`endif

endmodule
